// File: rtl/writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : writeback_queue
// Purpose  : Writeback-side producer for the register file write port.
//            Buffers ALU and load/store results in program order inside a
//            circular queue and retires one register write per cycle on
//            wr1/wrReg1/wrData1. It also forwards the newest pending value
//            for the two operand registers being read, so decode never
//            consumes a stale register value.
// Ports    : clk, reset        - clock (rising edge), synchronous active-high
//            ls_*              - load/store result (older of a same-cycle pair)
//            alu_*             - ALU result (younger of a same-cycle pair)
//            rd_reg1/rd_reg2   - operand registers to forward for
//            wr1/wrReg1/wrData1- registered register-file write port
//            fwdN_hit/fwdN_data- newest pending value for rd_regN
//            stall             - fewer than two free slots
//            overflow          - sticky: a result was dropped
//            count             - occupied queue entries
// Revision : 1.0 - initial release
// ============================================================================
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ls_valid,
    input  logic [REG_W-1:0]         ls_reg,
    input  logic [DATA_W-1:0]        ls_data,
    input  logic                     alu_valid,
    input  logic [REG_W-1:0]         alu_reg,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic [REG_W-1:0]         rd_reg1,
    input  logic [REG_W-1:0]         rd_reg2,
    output logic                     wr1,
    output logic [REG_W-1:0]         wrReg1,
    output logic [DATA_W-1:0]        wrData1,
    output logic                     fwd1_hit,
    output logic [DATA_W-1:0]        fwd1_data,
    output logic                     fwd2_hit,
    output logic [DATA_W-1:0]        fwd2_data,
    output logic                     stall,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_TWO   = c_CNT_W'(2);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [REG_W-1:0]   r_reg_mem  [DEPTH];
    logic [DATA_W-1:0]  r_data_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic               r_wr1;
    logic [REG_W-1:0]   r_wr_reg;
    logic [DATA_W-1:0]  r_wr_data;
    logic               r_overflow;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic               w_pop;
    logic [c_CNT_W-1:0] w_space;
    logic               w_ls_acc;
    logic               w_alu_acc;
    logic               w_drop;
    logic [1:0]         w_enq_cnt;
    logic               w_slot0_en;
    logic [REG_W-1:0]   w_slot0_reg;
    logic [DATA_W-1:0]  w_slot0_data;
    logic               w_slot1_en;
    logic [c_PTR_W-1:0] w_tail_p1;
    logic [c_PTR_W-1:0] w_head_nxt;
    logic [c_PTR_W-1:0] w_tail_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic               w_overflow_nxt;

    // The head pops whenever the queue held something at the start of the
    // cycle; that slot is therefore reusable by this cycle's enqueues.
    assign w_pop   = (r_count != '0);
    assign w_space = c_DEPTH - r_count + (w_pop ? c_ONE : '0);

    always_comb begin
        w_ls_acc  = 1'b0;
        w_alu_acc = 1'b0;
        if (ls_valid && alu_valid) begin
            // LS is the older result, so it claims the last free slot.
            w_ls_acc  = (w_space >= c_ONE);
            w_alu_acc = (w_space >= c_TWO);
        end else if (ls_valid) begin
            w_ls_acc  = (w_space >= c_ONE);
        end else if (alu_valid) begin
            w_alu_acc = (w_space >= c_ONE);
        end
    end

    assign w_drop    = (ls_valid && !w_ls_acc) || (alu_valid && !w_alu_acc);
    assign w_enq_cnt = {1'b0, w_ls_acc} + {1'b0, w_alu_acc};

    // The oldest accepted result lands at tail; only an accepted pair uses
    // tail+1, and that second entry is always the ALU result.
    assign w_slot0_en   = w_ls_acc || w_alu_acc;
    assign w_slot0_reg  = w_ls_acc ? ls_reg  : alu_reg;
    assign w_slot0_data = w_ls_acc ? ls_data : alu_data;
    assign w_slot1_en   = w_ls_acc && w_alu_acc;
    assign w_tail_p1    = r_tail + c_PTR_W'(1);

    assign w_head_nxt     = r_head + c_PTR_W'(w_pop);
    assign w_tail_nxt     = r_tail + c_PTR_W'(w_enq_cnt);
    assign w_count_nxt    = r_count + c_CNT_W'(w_enq_cnt) - c_CNT_W'(w_pop);
    assign w_overflow_nxt = r_overflow || w_drop;

    // ------------------------------------------------------------------
    // Control registers and write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_wr1      <= 1'b0;
            r_wr_reg   <= '0;
            r_wr_data  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
            r_wr1      <= w_pop;
            // Index and data hold their last value when nothing retires.
            if (w_pop) begin
                r_wr_reg  <= r_reg_mem[r_head];
                r_wr_data <= r_data_mem[r_head];
            end
        end
    end

    // Queue storage needs no reset: occupancy alone defines valid entries.
    // When full, tail equals head; the popped value is read before the
    // new entry overwrites that slot at the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_slot0_en) begin
                r_reg_mem[r_tail]  <= w_slot0_reg;
                r_data_mem[r_tail] <= w_slot0_data;
            end
            if (w_slot1_en) begin
                r_reg_mem[w_tail_p1]  <= alu_reg;
                r_data_mem[w_tail_p1] <= alu_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    // Slot k here is the k-th oldest occupied entry counted from head, so a
    // scan in increasing k visits entries from oldest to youngest.
    logic [c_PTR_W-1:0] w_age_idx [DEPTH];
    logic [DEPTH-1:0]   w_age_vld;

    for (genvar k = 0; k < DEPTH; k++) begin : g_age_slot
        assign w_age_idx[k] = r_head + c_PTR_W'(k);
        assign w_age_vld[k] = (c_CNT_W'(k) < r_count);
    end

    // The output register is the oldest candidate; each younger queue match
    // overrides the previous one, so the final value is the newest write.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_hit  = 1'b0;
        fwd2_data = '0;
        if (r_wr1 && (r_wr_reg == rd_reg1)) begin
            fwd1_hit  = 1'b1;
            fwd1_data = r_wr_data;
        end
        if (r_wr1 && (r_wr_reg == rd_reg2)) begin
            fwd2_hit  = 1'b1;
            fwd2_data = r_wr_data;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (w_age_vld[k] && (r_reg_mem[w_age_idx[k]] == rd_reg1)) begin
                fwd1_hit  = 1'b1;
                fwd1_data = r_data_mem[w_age_idx[k]];
            end
            if (w_age_vld[k] && (r_reg_mem[w_age_idx[k]] == rd_reg2)) begin
                fwd2_hit  = 1'b1;
                fwd2_data = r_data_mem[w_age_idx[k]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr1      = r_wr1;
    assign wrReg1   = r_wr_reg;
    assign wrData1  = r_wr_data;
    assign stall    = ((c_DEPTH - r_count) < c_TWO);
    assign overflow = r_overflow;
    assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_writeback_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_queue
// Purpose  : Self-checking bench for writeback_queue. Directed stimulus
//            pushes each accepted result onto an expected-write queue; an
//            independent monitor pops and compares on every wr1 pulse.
//            Occupancy, stall, overflow and forwarding are checked inline.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              ls_valid;
    logic [REG_W-1:0]  ls_reg;
    logic [DATA_W-1:0] ls_data;
    logic              alu_valid;
    logic [REG_W-1:0]  alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic [REG_W-1:0]  rd_reg1;
    logic [REG_W-1:0]  rd_reg2;
    logic              wr1;
    logic [REG_W-1:0]  wrReg1;
    logic [DATA_W-1:0] wrData1;
    logic              fwd1_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd2_data;
    logic              stall;
    logic              overflow;
    logic [$clog2(DEPTH):0] count;

    writeback_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .ls_valid  (ls_valid),
        .ls_reg    (ls_reg),
        .ls_data   (ls_data),
        .alu_valid (alu_valid),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .rd_reg1   (rd_reg1),
        .rd_reg2   (rd_reg2),
        .wr1       (wr1),
        .wrReg1    (wrReg1),
        .wrData1   (wrData1),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .stall     (stall),
        .overflow  (overflow),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [REG_W-1:0]  r;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t sb[$];
    wr_t m_exp;
    int  vectors     = 0;
    int  miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lv, input logic [REG_W-1:0] lr, input logic [DATA_W-1:0] ld,
                         input logic av, input logic [REG_W-1:0] ar, input logic [DATA_W-1:0] ad,
                         input logic l_acc, input logic a_acc);
        ls_valid  = lv;
        ls_reg    = lr;
        ls_data   = ld;
        alu_valid = av;
        alu_reg   = ar;
        alu_data  = ad;
        if (l_acc) sb.push_back({lr, ld});
        if (a_acc) sb.push_back({ar, ad});
    endtask

    task automatic idle();
        ls_valid  = 1'b0;
        alu_valid = 1'b0;
    endtask

    // Write-port monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (wr1 === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got reg %0d data 0x%0h, expected no write",
                         wrReg1, wrData1);
            end else begin
                m_exp = sb.pop_front();
                if ({wrReg1, wrData1} !== {m_exp.r, m_exp.d}) begin
                    miscompares++;
                    $display("FAIL write_port: got reg %0d data 0x%0h, expected reg %0d data 0x%0h",
                             wrReg1, wrData1, m_exp.r, m_exp.d);
                end
            end
        end
    end

    initial begin
        reset   = 1'b1;
        rd_reg1 = '0;
        rd_reg2 = '0;
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_wr1", 32'(wr1), 32'd0);
        check("rst_wrReg1", 32'(wrReg1), 32'd0);
        check("rst_wrData1", 32'(wrData1), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        // Single write: two-cycle latency to the write port
        rd_reg1 = 4'd3;
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'h1234, 1'b0, 1'b1);
        tick();
        idle();
        check("single_count_c1", 32'(count), 32'd1);
        check("single_wr1_c1", 32'(wr1), 32'd0);
        tick();
        check("single_wr1_c2", 32'(wr1), 32'd1);
        check("single_wrReg1_c2", 32'(wrReg1), 32'd3);
        check("single_wrData1_c2", 32'(wrData1), 32'h1234);
        check("single_fwd1_outreg_hit", 32'(fwd1_hit), 32'd1);
        check("single_fwd1_outreg_data", 32'(fwd1_data), 32'h1234);
        tick();
        check("single_wr1_c3", 32'(wr1), 32'd0);
        check("single_count_c3", 32'(count), 32'd0);
        check("single_fwd1_gone", 32'(fwd1_hit), 32'd0);

        // Dual enqueue: LS older than ALU, same destination register
        rd_reg1 = 4'd5;
        drive(1'b1, 4'd5, 16'h00AA, 1'b1, 4'd5, 16'h00BB, 1'b1, 1'b1);
        tick();
        idle();
        check("dual_count", 32'(count), 32'd2);
        check("dual_fwd1_hit_both", 32'(fwd1_hit), 32'd1);
        check("dual_fwd1_data_both", 32'(fwd1_data), 32'h00BB);
        tick();
        check("dual_count_after_pop", 32'(count), 32'd1);
        check("dual_fwd1_data_one", 32'(fwd1_data), 32'h00BB);
        tick();
        check("dual_count_empty", 32'(count), 32'd0);
        check("dual_fwd1_hit_outreg", 32'(fwd1_hit), 32'd1);
        check("dual_fwd1_data_outreg", 32'(fwd1_data), 32'h00BB);
        tick();
        check("dual_fwd1_hit_none", 32'(fwd1_hit), 32'd0);
        check("dual_fwd1_data_none", 32'(fwd1_data), 32'd0);
        check("dual_wr1_low", 32'(wr1), 32'd0);

        // Forward priority: queued entry beats the older output register
        rd_reg1 = 4'd9;
        rd_reg2 = 4'd7;
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 16'h0001, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd7, 16'h0002, 1'b0, 1'b1);
        tick();
        idle();
        check("prio_fwd2_hit", 32'(fwd2_hit), 32'd1);
        check("prio_fwd2_data", 32'(fwd2_data), 32'h0002);
        check("prio_fwd1_hit", 32'(fwd1_hit), 32'd0);
        check("prio_fwd1_data", 32'(fwd1_data), 32'd0);
        tick();
        tick();
        tick();
        check("prio_drained", 32'(count), 32'd0);

        // Full / stall / overflow with pointer wrap
        rd_reg1 = 4'd8;
        drive(1'b1, 4'd1, 16'h0101, 1'b1, 4'd2, 16'h0102, 1'b1, 1'b1);
        tick();
        check("full_count_2", 32'(count), 32'd2);
        check("full_stall_2", 32'(stall), 32'd0);
        drive(1'b1, 4'd3, 16'h0103, 1'b1, 4'd4, 16'h0104, 1'b1, 1'b1);
        tick();
        check("full_count_3", 32'(count), 32'd3);
        check("full_stall_3", 32'(stall), 32'd1);
        check("full_no_ovf_3", 32'(overflow), 32'd0);
        drive(1'b1, 4'd5, 16'h0105, 1'b1, 4'd6, 16'h0106, 1'b1, 1'b1);
        tick();
        check("full_count_4", 32'(count), 32'd4);
        check("full_stall_4", 32'(stall), 32'd1);
        check("full_no_ovf_4", 32'(overflow), 32'd0);
        drive(1'b1, 4'd7, 16'h0107, 1'b1, 4'd8, 16'h0108, 1'b1, 1'b0);
        tick();
        idle();
        check("full_count_keep", 32'(count), 32'd4);
        check("full_overflow_set", 32'(overflow), 32'd1);
        check("full_dropped_not_fwd", 32'(fwd1_hit), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        check("full_drained", 32'(count), 32'd0);
        check("full_overflow_sticky", 32'(overflow), 32'd1);
        check("full_stall_clear", 32'(stall), 32'd0);

        // Reset in the middle of activity
        drive(1'b1, 4'd10, 16'h0A0A, 1'b1, 4'd11, 16'h0B0B, 1'b1, 1'b1);
        tick();
        drive(1'b1, 4'd12, 16'h0C0C, 1'b1, 4'd13, 16'h0D0D, 1'b1, 1'b1);
        tick();
        check("mid_count_3", 32'(count), 32'd3);
        drive(1'b1, 4'd14, 16'h0E0E, 1'b1, 4'd15, 16'h0F0F, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        sb.delete();
        reset = 1'b0;
        idle();
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_wr1", 32'(wr1), 32'd0);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("mid_rst_stay_empty", 32'(count), 32'd0);

        // Steady stream of single ALU results
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 4'd0, 16'h0, 1'b1, 4'(i % 16), 16'(16'h5000 + i), 1'b0, 1'b1);
            tick();
            check("stream_count", 32'(count), 32'd1);
            check("stream_stall", 32'(stall), 32'd0);
            if (i >= 1) check("stream_wr1", 32'(wr1), 32'd1);
        end
        idle();
        for (int i = 0; i < 4; i++) tick();
        check("end_count", 32'(count), 32'd0);
        check("end_all_writes_seen", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Writeback-side producer for the register file's write port: accepts results from the ALU and load/store pipes, buffers them in program order, and drives wr1/wrReg1/wrData1 at one register write per cycle.
- Provides newest-value forwarding for the two operand register numbers the register file echoes (rd_reg1/rd_reg2), so decode never reads a stale value while a write is queued.
- Raises stall to the issue stage when the queue cannot absorb two more results.

Parameters:
DEPTH, 4, queue entries (power of 2, >=2)
DATA_W, 16, result width
REG_W, 4, register index width (16 registers)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
ls_valid  input  1  load/store result present this cycle
ls_reg  input  REG_W  destination register of LS result
ls_data  input  DATA_W  LS result (unsigned)
alu_valid  input  1  ALU result present this cycle
alu_reg  input  REG_W  destination register of ALU result
alu_data  input  DATA_W  ALU result (unsigned)
rd_reg1  input  REG_W  operand-1 register being read
rd_reg2  input  REG_W  operand-2 register being read
wr1  output  1  register write enable
wrReg1  output  REG_W  register write index
wrData1  output  DATA_W  register write data
fwd1_hit  output  1  pending write to rd_reg1 exists
fwd1_data  output  DATA_W  newest pending value for rd_reg1
fwd2_hit  output  1  pending write to rd_reg2 exists
fwd2_data  output  DATA_W  newest pending value for rd_reg2
stall  output  1  free slots < 2
overflow  output  1  sticky: a result was dropped
count  output  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (sync, clk edge with reset=1): queue empty (head=tail=0, count=0), wr1=0, wrReg1=0, wrData1=0, overflow=0. Reset overrides all same-cycle enqueues, dequeues and in-flight writes. Those results are lost, with no write issued.
- Queue: circular buffer with head/tail pointers, wrap modulo DEPTH. Entry = {reg, data}.
- Enqueue order within a cycle: LS result is older and is written at tail, ALU result at tail+1. A single valid result goes at tail.
- Dequeue: every cycle with count>0 (evaluated before this cycle's enqueues), head entry pops and is registered onto the write port.
  - Next edge: wr1=1, wrReg1/wrData1 = entry.
  - With count=0, wr1=0 next cycle. wrReg1/wrData1 hold their last value.
- No bypass from input straight to the write port. Minimum latency from a result's valid cycle to wr1 high is 2 cycles when the queue is empty.
- Occupancy: count_next = count + enqueued - popped. Pop and enqueue in the same cycle may use the freed slot.
- Space rule: space = DEPTH - count + pop.
  - If a result cannot fit, it is dropped and overflow sets (sticky until reset).
  - With one free slot and both valid, LS is kept and ALU is dropped.
- stall = (DEPTH - count) < 2, combinational from registered count. Producers honouring stall never overflow.
- Forwarding (combinational): for each rd_regN, search the queue entries and the write-port output register (while wr1=1).
  - Newest match wins. Priority: youngest queue entry (tail-1) down to head, then the output register.
  - Hit with no match: fwdN_hit=0, fwdN_data=0.
  - Same-cycle input results are not forwarded; they are visible one cycle later.
- Duplicates: multiple entries for the same register are allowed. Writes issue in order, so the final register value is the newest.
- No special case for r0; writes to any index are performed.

Test Plan:
- Single write: after reset, ALU valid reg=3 data=0x1234 at cycle 0 -> count=1 at cycle 1; wr1=1, wrReg1=3, wrData1=0x1234 at cycle 2; wr1=0 at cycle 3.
- Dual enqueue order: LS(reg=5, 0x00AA) and ALU(reg=5, 0x00BB) same cycle -> writes of 0x00AA then 0x00BB on consecutive cycles. fwd for rd_reg1=5 reads 0x00BB while both are pending, then 0x00BB from the output register, then hit=0.
- Full/stall: DEPTH=4, hold both inputs valid with distinct regs 1..8 -> stall=1 once count>=3. Pushing past capacity drops the ALU result when one slot remains and sets overflow=1. All accepted entries drain in order; the wrap-around pointer is exercised.
- Forward priority: enqueue reg=7 0x0001, then next cycle reg=7 0x0002 -> fwd2 with rd_reg2=7 gives hit=1, data=0x0002. rd_reg1=9 gives hit=0, data=0.
- Reset mid-operation: fill 3 entries, assert reset for one cycle with both inputs valid -> next cycle count=0, wr1=0, overflow=0, no further writes issued.
- Steady stream: ALU valid every cycle for 20 cycles, regs cycling 0..15 -> count stays 1, stall never asserts, and wr1 is high from cycle 2 onward with data matching the inputs delayed by 2.
